fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 34 +++
 rtl/fetch_buffer.sv | 64 ++++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings,
// buffer entry layout, NOP word and base opcode constants.
package fetch_pkg;

  // Legacy state encodings, kept so existing waveforms/decoders still match
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    REQ   = ST_REQ,
    WAIT  = ST_WAIT,
    FLUSH = ST_FLUSH
  } fetchState_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetchEntry_t;

  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous instruction buffer FIFO with single-cycle flush and
// occupancy count. Head entry is presented combinationally.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetchEntry_t              pushEntry,
  input  logic                     pop,
  output fetchEntry_t              headEntry,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  fetchEntry_t       store [DEPTH];
  logic [AW-1:0]     wrPtr;
  logic [AW-1:0]     rdPtr;
  logic [CW-1:0]     cnt;
  logic              full;
  logic              doPush;
  logic              doPop;

  assign full      = (cnt == FULL_C);
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign headEntry = store[rdPtr];

  // A pop frees the slot in the same edge, so a full buffer may still accept a push alongside it
  always_comb begin
    doPop  = pop && !empty && !flush;
    doPush = push && !flush && (!full || doPop);
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one edge
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (doPush) store[wrPtr] <= pushEntry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one outstanding word fetch at a time,
// buffers returned instructions for decode and handles PC redirects.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        pcSrc,
  input  logic [31:0] pcTarget,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [31:0] START_PC = alignPc(RESET_PC);

  fetchState_e   state;
  fetchState_e   nextState;
  logic [31:0]   fetchPc;
  logic [31:0]   reqPc;
  logic [31:0]   lastInstr;
  logic [31:0]   lastPc;
  logic          staleRsp;
  logic          grant;
  logic          bufPush;
  logic          bufPop;
  logic          bufEmpty;
  logic [CW-1:0] bufCount;
  fetchEntry_t   headEntry;
  fetchEntry_t   pushEntry;
  logic          unusedPcBits;

  assign unusedPcBits = ^pcTarget[1:0];

  // In REQ nothing is outstanding, so occupancy alone decides whether a fetch fits
  assign imem_req  = rst_n && (state == REQ) && (bufCount < DEPTH_C);
  assign imem_addr = fetchPc;
  assign grant     = imem_req && imem_gnt;

  // Redirect kills both a same-cycle response and a same-cycle consume
  assign bufPush   = (state == WAIT) && imem_rvalid && !pcSrc;
  assign bufPop    = !bufEmpty && dec_ready && !pcSrc;
  assign pushEntry = '{instr: imem_rdata, pc: reqPc};

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) uBuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (pcSrc),
    .push     (bufPush),
    .pushEntry(pushEntry),
    .pop      (bufPop),
    .headEntry(headEntry),
    .empty    (bufEmpty),
    .count    (bufCount)
  );

  assign dec_valid = !bufEmpty;
  assign dec_instr = bufEmpty ? lastInstr : headEntry.instr;
  assign dec_pc    = bufEmpty ? lastPc    : headEntry.pc;
  assign op        = dec_instr[6:0];
  assign funct3    = dec_instr[14:12];
  assign funct7    = dec_instr[30];

  // Next-state: a redirect while a response is owed parks in FLUSH to swallow it
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  nextState = (staleRsp && !imem_rvalid) ? FLUSH : REQ;
      REQ:   if (grant) nextState = pcSrc ? FLUSH : WAIT;
      WAIT: begin
        if (pcSrc)            nextState = imem_rvalid ? REQ : FLUSH;
        else if (imem_rvalid) nextState = REQ;
      end
      FLUSH: if (imem_rvalid) nextState = REQ;
      default: nextState = IDLE;
    endcase
  end

  // State, fetch PC and last-seen head; staleRsp survives reset so a response
  // owed from before reset is discarded once fetching restarts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetchPc   <= START_PC;
      reqPc     <= START_PC;
      lastInstr <= NOP;
      lastPc    <= START_PC;
      staleRsp  <= (staleRsp || state == WAIT || state == FLUSH) && !imem_rvalid;
    end else begin
      state    <= nextState;
      staleRsp <= 1'b0;
      if (pcSrc)      fetchPc <= alignPc(pcTarget);
      else if (grant) fetchPc <= fetchPc + 32'd4;
      if (grant) reqPc <= fetchPc;
      if (!bufEmpty) begin
        lastInstr <= headEntry.instr;
        lastPc    <= headEntry.pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counts of consumed instructions and redirects
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (bufPop && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (pcSrc && perf_flush_cnt != '1)  perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit (RESET_PC=0x100, BUF_DEPTH=2).
module tb_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        pcSrc;
  logic [31:0] pcTarget;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  int          nCompared = 0;
  int          nMismatch = 0;
  exp_t        expDec[$];
  logic [31:0] expFetchPc = 32'h100;
  int          grantCnt = 0;
  int          popCnt = 0;
  int          respLatency = 1;
  bit          discardNext = 1'b0;

  fetch_unit #(
    .RESET_PC (32'h0000_0100),
    .BUF_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .pcSrc      (pcSrc),
    .pcTarget   (pcTarget),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_instr  (dec_instr),
    .dec_pc     (dec_pc),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h0000_0100: return 32'h0000_A283;  // lw  x5,0(x1)
      32'h0000_0104: return 32'h0062_A023;  // sw  x6,0(x5)
      32'h0000_0108: return 32'h4020_8033;  // sub x0,x1,x2
      32'h0000_010C: return 32'h0020_8463;  // beq x1,x2,8
      default:       return {addr[21:2], 12'h033};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic waitGrant();
    int  i = 0;
    bit  found = 1'b0;
    while (!found && i < 20) begin
      @(negedge clk);
      found = imem_req && imem_gnt;
      i++;
    end
    if (!found) begin
      nCompared++;
      nMismatch++;
      $display("FAIL grant_timeout: got no grant expected one within 20 cycles");
    end
  endtask

  // Memory model: answers each grant after respLatency cycles and records the expected buffer entry
  initial begin
    logic [31:0] pendAddr;
    int          pendCnt;
    pendAddr    = '0;
    pendCnt     = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        pendAddr = imem_addr;
        pendCnt  = respLatency;
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (pendCnt > 0) begin
        pendCnt--;
        if (pendCnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memWord(pendAddr);
          if (discardNext) discardNext = 1'b0;
          else expDec.push_back('{instr: memWord(pendAddr), pc: pendAddr});
        end
      end
    end
  end

  // Request monitor: every granted address must follow the expected fetch PC sequence
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expFetchPc = 32'h100;
        grantCnt   = 0;
      end else begin
        if (imem_req && imem_gnt) begin
          check("imem_addr", imem_addr, expFetchPc);
          expFetchPc = expFetchPc + 32'd4;
          grantCnt++;
        end
        if (pcSrc) expFetchPc = {pcTarget[31:2], 2'b00};
      end
    end
  end

  // Decode monitor: pop the scoreboard on every consume; redirect or reset drops all pending entries
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || pcSrc) begin
        expDec.delete();
      end else if (dec_valid && dec_ready) begin
        if (expDec.size() == 0) begin
          nCompared++;
          nMismatch++;
          $display("FAIL dec_unexpected: got pc %h expected no entry", dec_pc);
        end else begin
          e = expDec.pop_front();
          popCnt++;
          check("dec_instr", dec_instr, e.instr);
          check("dec_pc", dec_pc, e.pc);
          check("op", {25'd0, op}, {25'd0, e.instr[6:0]});
          check("funct3", {29'd0, funct3}, {29'd0, e.instr[14:12]});
          check("funct7", {31'd0, funct7}, {31'd0, e.instr[30]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    imem_gnt  = 1'b1;
    pcSrc     = 1'b0;
    pcTarget  = '0;
    dec_ready = 1'b0;
    repeat (3) cyc();

    // Reset state
    @(negedge clk);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("rst_dec_instr", dec_instr, 32'h0000_0013);
    check("rst_dec_pc", dec_pc, 32'h0000_0100);
    check("rst_op", {25'd0, op}, 32'h13);

    // Release reset: one IDLE cycle, then first fetch at RESET_PC
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req", {31'd0, imem_req}, 32'd0);
    cyc();
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0000_0100);
    cyc();
    @(negedge clk);
    check("wait_req", {31'd0, imem_req}, 32'd0);
    check("wait_dec_valid", {31'd0, dec_valid}, 32'd0);
    cyc();
    @(negedge clk);
    check("lat_dec_valid", {31'd0, dec_valid}, 32'd1);
    check("lw_dec_pc", dec_pc, 32'h0000_0100);
    check("lw_dec_instr", dec_instr, 32'h0000_A283);
    check("lw_op", {25'd0, op}, 32'h03);
    check("lw_funct3", {29'd0, funct3}, 32'd2);
    check("lw_funct7", {31'd0, funct7}, 32'd0);
    check("second_addr", imem_addr, 32'h0000_0104);

    // Decode stalled: buffer of two fills, then no further requests
    repeat (8) cyc();
    check("stall_grants", grantCnt, 32'd2);
    @(negedge clk);
    check("stall_req", {31'd0, imem_req}, 32'd0);
    check("stall_head_pc", dec_pc, 32'h0000_0100);

    // Drain and stream
    cyc();
    dec_ready = 1'b1;
    repeat (12) cyc();

    // Redirect during WAIT: late response dropped, refetch at aligned target
    respLatency = 3;
    waitGrant();
    cyc();
    pcSrc       = 1'b1;
    pcTarget    = 32'h0000_0203;
    discardNext = 1'b1;
    cyc();
    pcSrc       = 1'b0;
    respLatency = 1;
    @(negedge clk);
    check("flush_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("flush_req", {31'd0, imem_req}, 32'd0);
    cyc();
    @(negedge clk);
    check("flush_req2", {31'd0, imem_req}, 32'd0);
    cyc();
    @(negedge clk);
    check("redir_req", {31'd0, imem_req}, 32'd1);
    check("redir_addr", imem_addr, 32'h0000_0200);
    check("redir_dec_valid", {31'd0, dec_valid}, 32'd0);

    // Redirect in the same cycle as rvalid: nothing written
    repeat (4) cyc();
    waitGrant();
    cyc();
    pcSrc    = 1'b1;
    pcTarget = 32'h0000_0300;
    cyc();
    pcSrc = 1'b0;
    @(negedge clk);
    check("coll_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("coll_req", {31'd0, imem_req}, 32'd1);
    check("coll_addr", imem_addr, 32'h0000_0300);

    // PC wrap at the top of the address space
    repeat (3) cyc();
    waitGrant();
    cyc();
    pcSrc    = 1'b1;
    pcTarget = 32'hFFFF_FFF8;
    cyc();
    pcSrc = 1'b0;
    @(negedge clk);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    repeat (2) cyc();
    @(negedge clk);
    check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    repeat (2) cyc();
    @(negedge clk);
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    check("wrap_addr2", imem_addr, 32'h0000_0000);

    // Reset in the middle of WAIT: the late response must be ignored
    respLatency = 4;
    repeat (2) cyc();
    waitGrant();
    cyc();
    rst_n       = 1'b0;
    discardNext = 1'b1;
    cyc();
    rst_n       = 1'b1;
    respLatency = 1;
    @(negedge clk);
    check("mrst_req", {31'd0, imem_req}, 32'd0);
    check("mrst_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("mrst_dec_instr", dec_instr, 32'h0000_0013);
    check("mrst_dec_pc", dec_pc, 32'h0000_0100);
    cyc();
    @(negedge clk);
    check("mrst_flush_req", {31'd0, imem_req}, 32'd0);
    cyc();
    @(negedge clk);
    check("mrst_late_dec_valid", {31'd0, dec_valid}, 32'd0);
    cyc();
    @(negedge clk);
    check("mrst_refetch_req", {31'd0, imem_req}, 32'd1);
    check("mrst_refetch_addr", imem_addr, 32'h0000_0100);
    check("mrst_refetch_dec_valid", {31'd0, dec_valid}, 32'd0);

    repeat (10) cyc();
    check("consumed_some", {31'd0, (popCnt >= 10)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
